mitchell_antilog: RTL and testbench
===================================

Name: mitchell_antilog

Overview:
- Back end of the Mitchell log multiplier: accepts two operands already converted to log form by the leading-one detector and adds them in the log domain.
- Converts the log sum back to a linear product (antilog).
- Two-stage elastic pipeline with valid/ready handshake on both sides; sits between the operand-side detectors and the product consumer.

Parameters:
- N, 8, operand width in bits. Derived: KW = $clog2(N) characteristic width, FW = N-1 fraction width, product width 2N.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts pair this cycle
- zero_a  in  1  operand A is zero
- k_a  in  KW  leading-one position of A
- x_a  in  N  fraction of A; x_a[N-2:0] is Q0.FW (bit N-2 weighs 0.5); x_a[N-1] ignored
- zero_b, k_b, x_b  in  1/KW/N  same for operand B
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2N  approximate A*B
- out_zero  out  1  product forced to zero (either operand zero)

Behaviour:
- Reset (async, active-high): stage valids v1=v2=0, all stage data registers 0, so out_valid=0, product=0, out_zero=0. in_ready=0 while rst high. Reset mid-stream discards all in-flight pairs with no output.
- Handshake: transfer on a side when valid&ready high at a rising edge. out_valid/product/out_zero are held stable while out_valid=1 and out_ready=0. No input-side valid-before-ready dependency.
- Pipeline advance:
  - en2 = !v2 | out_ready.
  - en1 = !v1 | en2.
  - in_ready = en1 & !rst. Combinational out_ready->in_ready path is permitted.
- Stage 1 (captured when en1; v1 <= in_valid & in_ready):
  - s = x_a[FW-1:0] + x_b[FW-1:0], FW+1 bits.
  - c = s[FW].
  - f1 = s[FW-1:0].
  - k1 = k_a + k_b + c, KW+1 bits, no overflow (max 2(N-1)+1).
  - z1 = zero_a | zero_b.
- Stage 2 (captured when en2; v2 <= v1):
  - product = ({1'b1, f1} << k1) >> FW, truncated toward zero, result fits 2N bits.
  - If z1 then product = 0 and out_zero = 1, else out_zero = 0.
- Latency: 2 cycles from accepted input to out_valid with out_ready held high. Throughput: 1 pair per cycle.
- Buffering: the pipeline holds at most 2 pairs. With out_ready low and both stages full, in_ready=0. A pair is accepted in the same cycle the output drains (out_ready=1, v2=1).
- Ordering: strict FIFO. No drop or duplication under any stall pattern.
- Bubbles: an empty stage does not block upstream. A v1=0 bubble is squeezed out when stage 2 stalls.
- Boundaries:
  - Fraction carry c=1 increments the characteristic (log-sum wrap into the next octave).
  - k_a=k_b=N-1 with maximal fractions gives the largest product without overflow.
  - Zero flags override k/x contents.

Test Plan:
- a=3,b=3 (k=1,x=0x40 each), out_ready=1 -> s=0x80, c=1, k1=3, product=8 two cycles after accept, out_zero=0.
- a=5,b=3 (k_a=2,x_a=0x20; k_b=1,x_b=0x40) -> no carry, k1=3, product=14. Also a=8,b=8 (k=3,x=0) -> product=64 exact.
- a=255,b=255 (k=7,x=0x7F each) -> c=1, f1=0x7E, k1=15, product=0xFE00 (65024), no overflow.
- zero_a=1 with b=77 (k_b=6,x_b=0x1A) -> product=0, out_zero=1.
- out_ready=0, drive 3 consecutive valid pairs -> first two accepted, in_ready=0 on third. out_valid held with product stable. Raise out_ready -> three products emerge in order, one per cycle, third accepted on the first drain cycle.
- Two pairs in flight, assert rst asynchronously mid-cycle -> out_valid=0 and product=0 immediately. After release, in_ready=1, no stale product appears, and the next pair completes with 2-cycle latency.

Source files
------------

// File: rtl/mitchell_antilog_if.sv
// rtl/mitchell_antilog_if.sv - operand/product handshake bundle for the Mitchell antilog back end
// slave is the pipeline's view; master is the driver/consumer view.
interface mitchell_antilog_if #(
  parameter int N = 8
);
  localparam int KW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic          zero_a;
  logic [KW-1:0] k_a;
  logic [N-1:0]  x_a;
  logic          zero_b;
  logic [KW-1:0] k_b;
  logic [N-1:0]  x_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*N-1:0] product;
  logic          out_zero;

  modport slave (
    input  in_valid, zero_a, k_a, x_a, zero_b, k_b, x_b, out_ready,
    output in_ready, out_valid, product, out_zero
  );

  modport master (
    output in_valid, zero_a, k_a, x_a, zero_b, k_b, x_b, out_ready,
    input  in_ready, out_valid, product, out_zero
  );
endinterface

// File: rtl/mitchell_antilog.sv
// rtl/mitchell_antilog.sv - log-domain add and antilog of two Mitchell operands
// Two-stage elastic pipeline: stage 1 sums the logs, stage 2 shifts the mantissa back out.
module mitchell_antilog #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  mitchell_antilog_if.slave   bus
);
  localparam int KW = $clog2(N);
  localparam int FW = N - 1;
  localparam int PW = 2 * N;
  localparam int WW = FW + PW;

  logic          w_en1;
  logic          w_en2;
  logic [FW:0]   w_s;
  logic [KW:0]   w_k;
  logic [WW-1:0] w_wide;
  logic          w_unused_bits;

  logic          r_v1;
  logic [FW-1:0] r_f1;
  logic [KW:0]   r_k1;
  logic          r_z1;

  logic          r_v2;
  logic [PW-1:0] r_prod;
  logic          r_zero;

  assign w_en2        = !r_v2 || bus.out_ready;
  assign w_en1        = !r_v1 || w_en2;
  assign bus.in_ready = w_en1 && !rst;

  // A fraction carry moves the log sum into the next octave.
  assign w_s = {1'b0, bus.x_a[FW-1:0]} + {1'b0, bus.x_b[FW-1:0]};
  assign w_k = {1'b0, bus.k_a} + {1'b0, bus.k_b} + {{KW{1'b0}}, w_s[FW]};

  // Wide enough that the largest shift loses nothing before the FW-bit drop.
  assign w_wide = {{(WW-N){1'b0}}, 1'b1, r_f1} << r_k1;

  assign w_unused_bits = ^{bus.x_a[N-1], bus.x_b[N-1], w_wide[FW-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_f1 <= '0;
      r_k1 <= '0;
      r_z1 <= 1'b0;
    end else if (w_en1) begin
      r_v1 <= bus.in_valid && bus.in_ready;
      if (bus.in_valid) begin
        r_f1 <= w_s[FW-1:0];
        r_k1 <= w_k;
        r_z1 <= bus.zero_a || bus.zero_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_prod <= '0;
      r_zero <= 1'b0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_zero <= r_z1;
        r_prod <= r_z1 ? '0 : w_wide[FW +: PW];
      end
    end
  end

  assign bus.out_valid = r_v2;
  assign bus.product   = r_prod;
  assign bus.out_zero  = r_zero;
endmodule

// File: tb/tb_mitchell_antilog.sv
// tb/tb_mitchell_antilog.sv - scoreboard bench for mitchell_antilog
// Expected products are queued on accept and compared in order on output transfer.
module tb_mitchell_antilog;
  localparam int N  = 8;
  localparam int KW = $clog2(N);
  localparam int FW = N - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mitchell_antilog_if #(.N(N)) bus ();

  mitchell_antilog #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] q_prod[$];
  logic        q_zero[$];
  logic [15:0] cur_prod;
  logic        cur_zero;
  logic        hold_v;
  logic [15:0] hold_prod;
  logic        hold_zero;
  bit          done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int msb_pos(input int a);
    for (int i = N - 1; i >= 0; i--) if (a[i]) return i;
    return 0;
  endfunction

  function automatic int frac_of(input int a);
    return (a << (FW - msb_pos(a))) & ((1 << FW) - 1);
  endfunction

  function automatic logic [15:0] model(input int a, input int b);
    int s;
    int k;
    longint m;
    if (a == 0 || b == 0) return 16'd0;
    s = frac_of(a) + frac_of(b);
    k = msb_pos(a) + msb_pos(b);
    if (s >= (1 << FW)) begin
      k = k + 1;
      s = s - (1 << FW);
    end
    m = longint'((1 << FW) + s);
    return 16'((m << k) >> FW);
  endfunction

  // A zero operand gets random k/x so the zero flag has to win.
  task automatic set_pair(input int a, input int b, input int exp);
    bus.zero_a = (a == 0);
    bus.k_a    = (a == 0) ? KW'($urandom) : KW'(msb_pos(a));
    bus.x_a    = (a == 0) ? N'($urandom) : N'(frac_of(a) | ($urandom_range(0, 1) << FW));
    bus.zero_b = (b == 0);
    bus.k_b    = (b == 0) ? KW'($urandom) : KW'(msb_pos(b));
    bus.x_b    = (b == 0) ? N'($urandom) : N'(frac_of(b) | ($urandom_range(0, 1) << FW));
    cur_prod   = (exp < 0) ? model(a, b) : 16'(exp);
    cur_zero   = (a == 0) || (b == 0);
  endtask

  task automatic send(input int a, input int b, input int exp);
    bit acc;
    acc = 1'b0;
    set_pair(a, b, exp);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q_prod.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", q_prod.size(), 0);
  endtask

  initial begin
    logic [15:0] p;
    logic        z;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_prod", bus.product, hold_prod);
          check("hold_zero", bus.out_zero, hold_zero);
        end
        hold_v    = bus.out_valid && !bus.out_ready;
        hold_prod = bus.product;
        hold_zero = bus.out_zero;
        if (bus.out_valid && bus.out_ready) begin
          if (q_prod.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            p = q_prod.pop_front();
            z = q_zero.pop_front();
            check("product", bus.product, p);
            check("out_zero", bus.out_zero, z);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          q_prod.push_back(cur_prod);
          q_zero.push_back(cur_zero);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_pair(1, 1, -1);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_product", bus.product, 0);
    check("rst_out_zero", bus.out_zero, 0);
    check("rst_in_ready", bus.in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.in_ready, 1);

    bus.out_ready = 1'b1;
    send(3, 3, 8);
    @(negedge clk);
    check("lat_cycle1", bus.out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", bus.out_valid, 1);
    check("lat_product", bus.product, 8);
    @(posedge clk);
    #1;
    send(5, 3, 14);
    send(8, 8, 64);
    send(255, 255, 65024);
    send(0, 77, 0);
    send(1, 1, 1);
    wait_drain();

    bus.out_ready = 1'b0;
    send(10, 20, -1);
    send(30, 40, -1);
    set_pair(50, 60, -1);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", bus.in_ready, 0);
      check("full_out_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("third_on_drain", bus.in_ready, 1);
    check("drain_seq", bus.out_valid, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("drain_seq", bus.out_valid, 1);
    end
    wait_drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int a;
          int b;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
          b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
          send(a, b, -1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    bus.out_ready = 1'b0;
    send(3, 5, -1);
    send(7, 9, -1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_product", bus.product, 0);
    check("midrst_out_zero", bus.out_zero, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    q_prod.delete();
    q_zero.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("ready_post_rst", bus.in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      check("no_stale", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(3, 3, 8);
    @(negedge clk);
    check("post_rst_lat1", bus.out_valid, 0);
    @(negedge clk);
    check("post_rst_lat2", bus.out_valid, 1);
    check("post_rst_product", bus.product, 8);
    wait_drain();

    check("sb_empty", q_prod.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
